serial_adder: RTL and testbench

- Multi-cycle, parametrised adder/subtractor that processes DIGIT bits per clock using an internal DIGIT-wide full-adder ripple slice and a registered carry.
- Successor to the single-bit combinational full adder. Adds operand width, digit-serial iteration, a start/done handshake and a subtract mode.
- Sits wherever area matters more than latency: iterative ALU datapaths and the multiplier accumulate step.

---
 rtl/serial_adder_if.sv | 37 +++
 rtl/serial_adder.sv | 140 ++++++++++++++
 tb/tb_serial_adder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the digit-serial adder.
// Optional overflow signal v exists only when SERIAL_ADDER_OVERFLOW_EN is defined.
`timescale 1ns/1ps
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             x;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             busy;
    logic             done;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             v;
`endif

    // Requester side: issues operations, observes results.
    modport master (
        output start, sub, a, b, x,
        input  s, c, busy, done
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , input v
`endif
    );

    // Adder side: accepts operations, produces results.
    modport slave (
        input  start, sub, a, b, x,
        output s, c, busy, done
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , output v
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor. Processes DIGIT bits per clock
// through a DIGIT-wide ripple slice with a registered carry; start/done handshake.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds signed-overflow output v.
`timescale 1ns/1ps
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] opa_reg, opa_next;
    logic [WIDTH-1:0] opb_reg, opb_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             c_reg, c_next;
    logic             done_reg, done_next;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] acc_shift;
    logic             last_step;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic             v_reg, v_next;
    logic             slice_ovf;
`endif

    // Ripple slice over the low digit of both operands plus the running carry;
    // its low bits enter the result register from the MSB end.
    always_comb begin
        slice     = {1'b0, opa_reg[DIGIT-1:0]} + {1'b0, opb_reg[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_reg};
        acc_shift = (acc_reg >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
        last_step = (cnt_reg == CW'(STEPS - 1));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        // Carry into the MSB is recovered from the MSB sum bit and its inputs.
        slice_ovf = slice[DIGIT] ^ (slice[DIGIT-1] ^ opa_reg[DIGIT-1] ^ opb_reg[DIGIT-1]);
`endif
    end

    // Next-state and datapath control: accept in IDLE, shift one digit per RUN cycle.
    always_comb begin
        state_next = state_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        acc_next   = acc_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        s_next     = s_reg;
        c_next     = c_reg;
        done_next  = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
        v_next     = v_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    opa_next   = bus.a;
                    // Subtraction is A + ~B + ~borrow; carry out then means "no borrow".
                    opb_next   = bus.sub ? ~bus.b : bus.b;
                    carry_next = bus.sub ^ bus.x;
                    cnt_next   = '0;
                    acc_next   = '0;
                end
            end
            RUN: begin
                opa_next   = opa_reg >> DIGIT;
                opb_next   = opb_reg >> DIGIT;
                acc_next   = acc_shift;
                carry_next = slice[DIGIT];
                cnt_next   = cnt_reg + CW'(1);
                if (last_step) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    s_next     = acc_shift;
                    c_next     = slice[DIGIT];
                    done_next  = 1'b1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                    v_next     = slice_ovf;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            opa_reg   <= '0;
            opb_reg   <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            c_reg     <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            v_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            s_reg     <= s_next;
            c_reg     <= c_next;
            done_reg  <= done_next;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            v_reg     <= v_next;
`endif
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.s    = s_reg;
    assign bus.c    = c_reg;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.v    = v_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed bench for serial_adder with two
// instances (bit-serial DIGIT=1 and DIGIT=4), checked against an integer model.
`timescale 1ns/1ps
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start1 = 1'b0;
    logic         start4 = 1'b0;
    logic         sub_in = 1'b0;
    logic         x_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_s1 = '0;
    logic         last_c1 = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) if1 ();
    serial_adder_if #(.WIDTH(W)) if4 ();

    assign if1.start = start1;
    assign if1.sub   = sub_in;
    assign if1.a     = a_in;
    assign if1.b     = b_in;
    assign if1.x     = x_in;
    assign if4.start = start4;
    assign if4.sub   = sub_in;
    assign if4.a     = a_in;
    assign if4.b     = b_in;
    assign if4.x     = x_in;

    serial_adder #(.WIDTH(W), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    // Reference: plain signed/unsigned integer arithmetic.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic x,
                         input logic sub, output logic [W-1:0] s, output logic c,
                         output logic v);
        int r;
        int sr;
        r  = sub ? int'(a) - int'(b) - int'(x) : int'(a) + int'(b) + int'(x);
        sr = sub ? int'($signed(a)) - int'($signed(b)) - int'(x)
                 : int'($signed(a)) + int'($signed(b)) + int'(x);
        s  = r[W-1:0];
        c  = sub ? (r >= 0) : (r > 255);
        v  = (sr > 127) || (sr < -128);
    endtask

    // Runs one complete operation on the selected instance and checks it.
    task automatic exec_op(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic x, input logic sub, input string tag,
                           output logic [W-1:0] obs_s, output logic obs_c);
        logic [W-1:0] exp_s;
        logic         exp_c, exp_v, obs_busy, obs_done;
        int           cycles, steps;
        steps = sel ? 2 : 8;
        model(a, b, x, sub, exp_s, exp_c, exp_v);
        @(negedge clk);
        a_in = a; b_in = b; x_in = x; sub_in = sub;
        if (sel) start4 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        obs_busy = sel ? if4.busy : if1.busy;
        obs_done = sel ? if4.done : if1.done;
        checks++;
        if (obs_busy !== 1'b1 || obs_done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b want busy=1 done=0", tag, obs_busy, obs_done);
        end
        cycles = 0;
        while ((sel ? if4.done : if1.done) !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != steps) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, cycles, steps);
        end
        obs_s    = sel ? if4.s : if1.s;
        obs_c    = sel ? if4.c : if1.c;
        obs_busy = sel ? if4.busy : if1.busy;
        checks++;
        if (obs_s !== exp_s || obs_c !== exp_c || obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: s=%h c=%b busy=%b want s=%h c=%b busy=0",
                     tag, obs_s, obs_c, obs_busy, exp_s, exp_c);
        end
`ifdef SERIAL_ADDER_OVERFLOW_EN
        checks++;
        if ((sel ? if4.v : if1.v) !== exp_v) begin
            errors++;
            $display("FAIL %s overflow: v=%b want %b", tag, (sel ? if4.v : if1.v), exp_v);
        end
`endif
        @(negedge clk);
        obs_done = sel ? if4.done : if1.done;
        checks++;
        if (obs_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b want 0", tag, obs_done);
        end
        if (!sel) begin
            last_s1 = exp_s;
            last_c1 = exp_c;
        end
        $display("op %s dut%0d a=%h b=%h x=%0b sub=%0b -> s=%h c=%0b latency=%0d",
                 tag, sel ? 4 : 1, a, b, x, sub, obs_s, obs_c, cycles);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if1.s !== 8'h00 || if1.c !== 1'b0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1: s=%h c=%b busy=%b done=%b want all 0",
                     if1.s, if1.c, if1.busy, if1.done);
        end
        checks++;
        if (if4.s !== 8'h00 || if4.c !== 1'b0 || if4.busy !== 1'b0 || if4.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut4: s=%h c=%b busy=%b done=%b want all 0",
                     if4.s, if4.c, if4.busy, if4.done);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_directed();
        logic [W-1:0] s;
        logic         c;
        exec_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, "add_5a_3c", s, c);
        checks++;
        if (s !== 8'h96 || c !== 1'b0) begin
            errors++; $display("FAIL add_5a_3c const: s=%h c=%b want s=96 c=0", s, c);
        end
        exec_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, "add_ff_01", s, c);
        checks++;
        if (s !== 8'h00 || c !== 1'b1) begin
            errors++; $display("FAIL add_ff_01 const: s=%h c=%b want s=00 c=1", s, c);
        end
        exec_op(1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, "add_ff_00_x", s, c);
        checks++;
        if (s !== 8'h00 || c !== 1'b1) begin
            errors++; $display("FAIL add_ff_00_x const: s=%h c=%b want s=00 c=1", s, c);
        end
        exec_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, "sub_10_20", s, c);
        checks++;
        if (s !== 8'hF0 || c !== 1'b0) begin
            errors++; $display("FAIL sub_10_20 const: s=%h c=%b want s=f0 c=0", s, c);
        end
        exec_op(1'b0, 8'h20, 8'h10, 1'b1, 1'b1, "sub_20_10_x", s, c);
        checks++;
        if (s !== 8'h0F || c !== 1'b1) begin
            errors++; $display("FAIL sub_20_10_x const: s=%h c=%b want s=0f c=1", s, c);
        end
    endtask

    task automatic test_ignore_midrun();
        logic [W-1:0] exp_s;
        logic         exp_c, exp_v;
        int           cycles;
        int           held_bad;
        model(8'h33, 8'h44, 1'b0, 1'b0, exp_s, exp_c, exp_v);
        @(negedge clk);
        a_in = 8'h33; b_in = 8'h44; x_in = 1'b0; sub_in = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cycles = 0;
        held_bad = 0;
        repeat (2) begin
            @(negedge clk); cycles++;
            if (if1.s !== last_s1 || if1.c !== last_c1) held_bad++;
        end
        a_in = 8'hAA; b_in = 8'h55; x_in = 1'b1; sub_in = 1'b1; start1 = 1'b1;
        repeat (2) begin
            @(negedge clk); cycles++;
            if (if1.s !== last_s1 || if1.c !== last_c1) held_bad++;
        end
        start1 = 1'b0;
        checks++;
        if (held_bad != 0) begin
            errors++;
            $display("FAIL midrun_hold: %0d cycles with changed s/c, want 0", held_bad);
        end
        while (if1.done !== 1'b1 && cycles < 40) begin
            @(negedge clk); cycles++;
        end
        checks++;
        if (cycles != 8 || if1.s !== exp_s || if1.c !== exp_c) begin
            errors++;
            $display("FAIL midrun_ignore: latency=%0d s=%h c=%b want latency=8 s=%h c=%b",
                     cycles, if1.s, if1.c, exp_s, exp_c);
        end
        @(negedge clk);
        checks++;
        if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_idle: busy=%b done=%b want 0 0", if1.busy, if1.done);
        end
        last_s1 = exp_s; last_c1 = exp_c;
        $display("op midrun_ignore dut1 a=33 b=44 -> s=%h c=%0b", if1.s, if1.c);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp1_s, exp2_s;
        logic         exp1_c, exp2_c, exp_v;
        int           cycles;
        model(8'h12, 8'h34, 1'b0, 1'b0, exp1_s, exp1_c, exp_v);
        model(8'h80, 8'h01, 1'b0, 1'b1, exp2_s, exp2_c, exp_v);
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; x_in = 1'b0; sub_in = 1'b0; start1 = 1'b1;
        @(negedge clk);
        a_in = 8'h80; b_in = 8'h01; x_in = 1'b0; sub_in = 1'b1;
        cycles = 0;
        while (if1.done !== 1'b1 && cycles < 40) begin
            @(negedge clk); cycles++;
        end
        checks++;
        if (cycles != 8 || if1.s !== exp1_s || if1.c !== exp1_c || if1.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: latency=%0d s=%h c=%b busy=%b want 8 %h %b 0",
                     cycles, if1.s, if1.c, if1.busy, exp1_s, exp1_c);
        end
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (if1.done !== 1'b0 || if1.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: done=%b busy=%b want done=0 busy=1", if1.done, if1.busy);
        end
        cycles = 0;
        while (if1.done !== 1'b1 && cycles < 40) begin
            @(negedge clk); cycles++;
        end
        checks++;
        if (cycles != 8 || if1.s !== exp2_s || if1.c !== exp2_c) begin
            errors++;
            $display("FAIL b2b_second: latency=%0d s=%h c=%b want 8 %h %b",
                     cycles, if1.s, if1.c, exp2_s, exp2_c);
        end
        @(negedge clk);
        last_s1 = exp2_s; last_c1 = exp2_c;
        $display("op back_to_back dut1 12+34 then 80-01 -> s=%h c=%0b", exp2_s, exp2_c);
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] s;
        logic         c;
        int           seen_done;
        @(negedge clk);
        a_in = 8'h7E; b_in = 8'h23; x_in = 1'b0; sub_in = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (if1.s !== 8'h00 || if1.c !== 1'b0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: s=%h c=%b busy=%b done=%b want all 0",
                     if1.s, if1.c, if1.busy, if1.done);
        end
        seen_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (if1.done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_no_done: done seen %0d times want 0", seen_done);
        end
        last_s1 = '0; last_c1 = 1'b0;
        exec_op(1'b0, 8'hC3, 8'h5D, 1'b1, 1'b0, "after_reset", s, c);
    endtask

    task automatic test_digit4();
        logic [W-1:0] s;
        logic         c;
        exec_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, "d4_7f_01", s, c);
        checks++;
        if (s !== 8'h80 || c !== 1'b0) begin
            errors++; $display("FAIL d4_7f_01 const: s=%h c=%b want s=80 c=0", s, c);
        end
        exec_op(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, "d4_01_01", s, c);
        checks++;
        if (s !== 8'h02 || c !== 1'b0) begin
            errors++; $display("FAIL d4_01_01 const: s=%h c=%b want s=02 c=0", s, c);
        end
        exec_op(1'b1, 8'h10, 8'h20, 1'b0, 1'b1, "d4_sub", s, c);
        exec_op(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, "d4_ovf_neg", s, c);
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        logic         c;
        for (int i = 0; i < 24; i++) begin
            exec_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), "random", s, c);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_midrun();
        test_back_to_back();
        test_reset_midrun();
        test_digit4();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
